// File: rtl/countdown_timer_if.sv
// Control/status bundle between a countdown_timer and whatever drives it.
// Latency: none, wires only.
// Backpressure: none; every signal is level-sampled on each system clock.
interface countdown_timer_if #(
   parameter int WIDTH = 4
);
   logic             iLoad;
   logic [WIDTH-1:0] iLoadVal;
   logic             iStart;
   logic             iPause;
   logic [WIDTH-1:0] oCount;
   logic             oTick1Hz;
   logic             oBusy;
   logic             oDone;

   // Timer side
   modport slave (
      input  iLoad, iLoadVal, iStart, iPause,
      output oCount, oTick1Hz, oBusy, oDone
   );

   // Controller side
   modport master (
      output iLoad, iLoadVal, iStart, iPause,
      input  oCount, oTick1Hz, oBusy, oDone
   );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting 1 Hz timer with an internal clock-enable divider; counts a loaded value to zero.
// Latency: iStart at edge n -> RUN from cycle n+1; first tick CLK_FREQ cycles after entering RUN.
// Backpressure: none; controls are level-sampled each cycle with priority iLoad > tick > iPause > iStart.
module countdown_timer #(
   parameter int CLK_FREQ = 50000000,   // system clock cycles per second, must be >= 2
   parameter int WIDTH    = 4
) (
   input  logic              iClk,
   input  logic              iRst_n,
   countdown_timer_if.slave  bus
);

   localparam int                DIV_W   = $clog2(CLK_FREQ);
   localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_FREQ - 1);
   localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] divCnt;
   logic [WIDTH-1:0] count;
   logic             tick;

   // The one-second strobe exists only while actually running; PAUSE holds divCnt so it cannot fire.
   assign tick = (state == RUN) && (divCnt == DIV_MAX);

   // Single state machine owning state, divider and count so their updates stay in lock-step.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state  <= IDLE;
         divCnt <= '0;
         count  <= '0;
      end else if (bus.iLoad) begin
         // Load aborts whatever is going on, with no done pulse.
         state  <= IDLE;
         divCnt <= '0;
         count  <= bus.iLoadVal;
      end else begin
         case (state)
            IDLE: begin
               divCnt <= '0;
               if (bus.iStart) begin
                  // A zero start value has nothing to count, so report done straight away.
                  state <= (count == '0) ? DONE : RUN;
               end
            end

            RUN: begin
               if (tick) begin
                  divCnt <= '0;
                  if (count <= ONE) begin
                     // Reaching zero beats a simultaneous pause; <= keeps count from wrapping.
                     count <= '0;
                     state <= DONE;
                  end else begin
                     count <= count - ONE;
                     if (bus.iPause) begin
                        state <= PAUSE;
                     end
                  end
               end else if (bus.iPause) begin
                  // Freeze divider and count exactly where they are.
                  state <= PAUSE;
               end else begin
                  divCnt <= divCnt + DIV_W'(1);
               end
            end

            PAUSE: begin
               // Resume only on a clean start; divCnt is held so the partial second is kept.
               if (bus.iStart && !bus.iPause) begin
                  state <= RUN;
               end
            end

            DONE: begin
               divCnt <= '0;
               state  <= IDLE;
            end

            default: begin
               state  <= IDLE;
               divCnt <= '0;
            end
         endcase
      end
   end

   assign bus.oCount   = count;
   assign bus.oTick1Hz = tick;
   assign bus.oBusy    = (state == RUN) || (state == PAUSE);
   assign bus.oDone    = (state == DONE);

endmodule
